// File: rtl/uncache_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uncache_wbuf                                                 |
// | Description : Uncached store write buffer. A circular FIFO feeds a 3-state |
// |               bus FSM (IDLE/REQ/WAIT). Loads stall behind buffered stores. |
// |               Define UNCACHE_WBUF_LOAD_CHECK_EN to stall only on a word     |
// |               address match instead of on any non-empty buffer.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uncache_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_StoreValid,
  input  logic [31:0] MEM_StoreAddr,
  input  logic [31:0] MEM_StoreData,
  input  logic [3:0]  MEM_StoreStrb,
  input  logic        MEM_LoadValid,
  input  logic [31:0] MEM_LoadAddr,
  output logic        WBuf_StallReq,
  output logic        Bus_WrReq,
  output logic [31:0] Bus_WrAddr,
  output logic [31:0] Bus_WrData,
  output logic [3:0]  Bus_WrStrb,
  input  logic        Bus_AddrOk,
  input  logic        Bus_DataOk,
  output logic        WBuf_Empty,
  output logic        WBuf_Full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        addr_mem_q [DEPTH];
  logic [31:0]        data_mem_q [DEPTH];
  logic [3:0]         strb_mem_q [DEPTH];

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_load_conflict;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_W'(DEPTH));
  // Full blocks the push even when a pop frees a slot in the same cycle.
  assign w_push  = MEM_StoreValid & ~w_full;
  assign w_pop   = (state_q == ST_WAIT) & Bus_DataOk;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_push) tail_d = tail_q + 1'b1;
    if (w_pop)  head_d = head_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!w_empty)  state_d = ST_REQ;
      ST_REQ:  if (Bus_AddrOk) state_d = ST_WAIT;
      ST_WAIT: if (w_pop)      state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      addr_mem_q[tail_q] <= MEM_StoreAddr;
      data_mem_q[tail_q] <= MEM_StoreData;
      strb_mem_q[tail_q] <= MEM_StoreStrb;
    end
  end

`ifdef UNCACHE_WBUF_LOAD_CHECK_EN
  logic [DEPTH-1:0] w_match;
  logic [1:0]       unused_load_lsb;

  assign unused_load_lsb = MEM_LoadAddr[1:0];

  // Slot i is live when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] w_off;
    assign w_off       = PTR_W'(gi) - head_q;
    assign w_match[gi] = ({1'b0, w_off} < count_q) &&
                         (addr_mem_q[gi][31:2] == MEM_LoadAddr[31:2]);
  end

  assign w_load_conflict = MEM_LoadValid & (|w_match);
`else
  logic unused_load_addr;

  assign unused_load_addr = ^MEM_LoadAddr;
  assign w_load_conflict  = MEM_LoadValid & ~w_empty;
`endif

  assign WBuf_StallReq = (MEM_StoreValid & w_full) | w_load_conflict;
  assign WBuf_Empty    = w_empty;
  assign WBuf_Full     = w_full;

  assign Bus_WrReq  = (state_q == ST_REQ);
  assign Bus_WrAddr = Bus_WrReq ? addr_mem_q[head_q] : 32'd0;
  assign Bus_WrData = Bus_WrReq ? data_mem_q[head_q] : 32'd0;
  assign Bus_WrStrb = Bus_WrReq ? strb_mem_q[head_q] : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_uncache_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uncache_wbuf                                              |
// | Description : Directed self-checking bench for uncache_wbuf (DEPTH=4).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uncache_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_StoreValid;
  logic [31:0] MEM_StoreAddr;
  logic [31:0] MEM_StoreData;
  logic [3:0]  MEM_StoreStrb;
  logic        MEM_LoadValid;
  logic [31:0] MEM_LoadAddr;
  logic        WBuf_StallReq;
  logic        Bus_WrReq;
  logic [31:0] Bus_WrAddr;
  logic [31:0] Bus_WrData;
  logic [3:0]  Bus_WrStrb;
  logic        Bus_AddrOk;
  logic        Bus_DataOk;
  logic        WBuf_Empty;
  logic        WBuf_Full;

  int n_chk  = 0;
  int n_fail = 0;

  uncache_wbuf #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_StoreValid (MEM_StoreValid),
    .MEM_StoreAddr  (MEM_StoreAddr),
    .MEM_StoreData  (MEM_StoreData),
    .MEM_StoreStrb  (MEM_StoreStrb),
    .MEM_LoadValid  (MEM_LoadValid),
    .MEM_LoadAddr   (MEM_LoadAddr),
    .WBuf_StallReq  (WBuf_StallReq),
    .Bus_WrReq      (Bus_WrReq),
    .Bus_WrAddr     (Bus_WrAddr),
    .Bus_WrData     (Bus_WrData),
    .Bus_WrStrb     (Bus_WrStrb),
    .Bus_AddrOk     (Bus_AddrOk),
    .Bus_DataOk     (Bus_DataOk),
    .WBuf_Empty     (WBuf_Empty),
    .WBuf_Full      (WBuf_Full)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    for (int k = 0; k < 20 && !Bus_WrReq; k++) tick();
    chk(tag, {31'd0, Bus_WrReq}, 32'd1);
  endtask

  task automatic wait_empty(input string tag);
    for (int k = 0; k < 20 && !WBuf_Empty; k++) tick();
    chk(tag, {31'd0, WBuf_Empty}, 32'd1);
  endtask

  // Expects Bus_AddrOk=1; checks the request then lets it be accepted.
  task automatic drain_expect(input string tag, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
    wait_req({tag, "_req"});
    chk({tag, "_addr"}, Bus_WrAddr, a);
    chk({tag, "_data"}, Bus_WrData, d);
    chk({tag, "_strb"}, {28'd0, Bus_WrStrb}, {28'd0, s});
    tick();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    MEM_StoreValid = 1'b1;
    MEM_StoreAddr  = a;
    MEM_StoreData  = d;
    MEM_StoreStrb  = s;
    tick();
    MEM_StoreValid = 1'b0;
  endtask

  initial begin
    logic exp_far_stall;
    rst = 1'b1;
    MEM_StoreValid = 1'b0; MEM_StoreAddr = '0; MEM_StoreData = '0; MEM_StoreStrb = '0;
    MEM_LoadValid = 1'b0;  MEM_LoadAddr = '0;
    Bus_AddrOk = 1'b0;     Bus_DataOk = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_req",   {31'd0, Bus_WrReq},     32'd0);
    chk("rst_addr",  Bus_WrAddr,             32'd0);
    chk("rst_empty", {31'd0, WBuf_Empty},    32'd1);
    chk("rst_full",  {31'd0, WBuf_Full},     32'd0);
    chk("rst_stall", {31'd0, WBuf_StallReq}, 32'd0);

    // Single store, AddrOk tied high, DataOk after a wait cycle.
    Bus_AddrOk = 1'b1;
    push(32'h1FAF_F000, 32'h0000_00AB, 4'hF);
    chk("t1_notempty", {31'd0, WBuf_Empty}, 32'd0);
    chk("t1_idle_req", {31'd0, Bus_WrReq},  32'd0);
    tick();
    chk("t1_req",  {31'd0, Bus_WrReq},      32'd1);
    chk("t1_addr", Bus_WrAddr,              32'h1FAF_F000);
    chk("t1_data", Bus_WrData,              32'h0000_00AB);
    chk("t1_strb", {28'd0, Bus_WrStrb},     32'hF);
    tick();
    chk("t1_req_one", {31'd0, Bus_WrReq},   32'd0);
    tick();
    chk("t1_wait_empty", {31'd0, WBuf_Empty}, 32'd0);
    Bus_DataOk = 1'b1;
    tick();
    Bus_DataOk = 1'b0;
    chk("t1_empty", {31'd0, WBuf_Empty}, 32'd1);
    tick();
    chk("t1_idle", {31'd0, Bus_WrReq}, 32'd0);

    // Five back-to-back stores with AddrOk held low: fifth is refused.
    Bus_AddrOk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      MEM_StoreValid = 1'b1;
      MEM_StoreAddr  = 32'h1FD0_1000 + 32'(i * 4);
      MEM_StoreData  = 32'hA5A5_0000 + 32'(i);
      MEM_StoreStrb  = 4'(1 << (i % 4));
      #1;
      chk($sformatf("t2_stall%0d", i), {31'd0, WBuf_StallReq}, (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    MEM_StoreValid = 1'b0;
    chk("t2_full", {31'd0, WBuf_Full}, 32'd1);
    Bus_AddrOk = 1'b1; Bus_DataOk = 1'b1;
    for (int i = 0; i < 4; i++)
      drain_expect($sformatf("t2_e%0d", i), 32'h1FD0_1000 + 32'(i * 4),
                   32'hA5A5_0000 + 32'(i), 4'(1 << i));
    wait_empty("t2_empty");
    tick(); tick();
    chk("t2_no5th", {31'd0, Bus_WrReq}, 32'd0);

    // Load hazard against a buffered store.
    Bus_AddrOk = 1'b0; Bus_DataOk = 1'b0;
    push(32'h1FD0_0010, 32'hCAFE_0010, 4'hF);
    MEM_LoadValid = 1'b1;
    MEM_LoadAddr  = 32'h1FD0_0010;
    #1;
    chk("t3_hit_stall", {31'd0, WBuf_StallReq}, 32'd1);
    MEM_LoadAddr = 32'h1FD0_0020;
    #1;
`ifdef UNCACHE_WBUF_LOAD_CHECK_EN
    exp_far_stall = 1'b0;
`else
    exp_far_stall = 1'b1;
`endif
    chk("t3_miss_stall", {31'd0, WBuf_StallReq}, {31'd0, exp_far_stall});
    MEM_LoadAddr = 32'h1FD0_0010;
    tick();
    chk("t3_hold_stall", {31'd0, WBuf_StallReq}, 32'd1);
    Bus_AddrOk = 1'b1; Bus_DataOk = 1'b1;
    drain_expect("t3_e0", 32'h1FD0_0010, 32'hCAFE_0010, 4'hF);
    wait_empty("t3_empty");
    #1;
    chk("t3_released", {31'd0, WBuf_StallReq}, 32'd0);
    MEM_LoadValid = 1'b0;

    // Simultaneous push and pop with two entries buffered.
    Bus_AddrOk = 1'b0; Bus_DataOk = 1'b0;
    tick();
    push(32'h1FC0_0100, 32'h0000_0011, 4'h3);
    push(32'h1FC0_0104, 32'h0000_0022, 4'hC);
    wait_req("t4_req0");
    chk("t4_addr0", Bus_WrAddr, 32'h1FC0_0100);
    Bus_AddrOk = 1'b1;
    tick();
    Bus_AddrOk = 1'b0;
    Bus_DataOk = 1'b1;
    push(32'h1FC0_0108, 32'h0000_0033, 4'h5);
    Bus_DataOk = 1'b0;
    chk("t4_back_req", {31'd0, Bus_WrReq}, 32'd1);
    chk("t4_head_adv", Bus_WrAddr,         32'h1FC0_0104);
    chk("t4_not_full", {31'd0, WBuf_Full}, 32'd0);
    Bus_AddrOk = 1'b1; Bus_DataOk = 1'b1;
    drain_expect("t4_e1", 32'h1FC0_0104, 32'h0000_0022, 4'hC);
    drain_expect("t4_e2", 32'h1FC0_0108, 32'h0000_0033, 4'h5);
    wait_empty("t4_empty");

    // Reset while waiting on the bus with three entries held.
    Bus_AddrOk = 1'b0; Bus_DataOk = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) push(32'h1FE0_0000 + 32'(i * 4), 32'(i), 4'hF);
    wait_req("t5_req");
    Bus_AddrOk = 1'b1;
    tick();
    Bus_AddrOk = 1'b0;
    chk("t5_in_wait", {31'd0, Bus_WrReq}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_req",   {31'd0, Bus_WrReq},  32'd0);
    chk("t5_empty", {31'd0, WBuf_Empty}, 32'd1);
    chk("t5_full",  {31'd0, WBuf_Full},  32'd0);
    chk("t5_addr",  Bus_WrAddr,          32'd0);
    Bus_DataOk = 1'b1;
    tick(); tick();
    Bus_DataOk = 1'b0;
    chk("t5_dataok_ignored", {31'd0, WBuf_Empty}, 32'd1);
    chk("t5_still_idle",     {31'd0, Bus_WrReq},  32'd0);

    // Six entries through the ring, crossing pointer wrap 3->0.
    push(32'h1FB0_0000, 32'h6000_0000, 4'h1);
    push(32'h1FB0_0004, 32'h6000_0001, 4'h2);
    push(32'h1FB0_0008, 32'h6000_0002, 4'h4);
    Bus_AddrOk = 1'b1; Bus_DataOk = 1'b1;
    drain_expect("t6_e0", 32'h1FB0_0000, 32'h6000_0000, 4'h1);
    drain_expect("t6_e1", 32'h1FB0_0004, 32'h6000_0001, 4'h2);
    Bus_AddrOk = 1'b0;
    tick();
    push(32'h1FB0_000C, 32'h6000_0003, 4'h8);
    push(32'h1FB0_0010, 32'h6000_0004, 4'h3);
    push(32'h1FB0_0014, 32'h6000_0005, 4'hC);
    chk("t6_full", {31'd0, WBuf_Full}, 32'd1);
    Bus_AddrOk = 1'b1;
    drain_expect("t6_e2", 32'h1FB0_0008, 32'h6000_0002, 4'h4);
    drain_expect("t6_e3", 32'h1FB0_000C, 32'h6000_0003, 4'h8);
    drain_expect("t6_e4", 32'h1FB0_0010, 32'h6000_0004, 4'h3);
    drain_expect("t6_e5", 32'h1FB0_0014, 32'h6000_0005, 4'hC);
    wait_empty("t6_empty");
    Bus_AddrOk = 1'b0; Bus_DataOk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
